ball_motion: RTL and testbench
==============================

# ball_motion

Ball physics engine for the Pong display. It owns the ball's centre coordinate and velocity, and advances the ball once per frame tick. It reflects the ball off the left, right and top walls and off the player paddle, and reports hits and misses. Its outputs feed the pixel renderer's circle test directly, in place of a line-drawer trace.

## Interface
- WIDTH, 640, screen width in pixels
- HEIGHT, 480, screen height in pixels
- RADIUS, 10, ball radius in pixels
- STEP, 2, per-tick speed magnitude on each axis, in pixels
- TICK_DIV, 1000000, CLOCK_50 cycles per motion tick
- CLOCK_50  input  1  system clock
- rst  input  1  synchronous, active-high reset
- serve  input  1  one-cycle launch pulse from a Click debouncer
- paddle_left  input  10  paddle left x, inclusive
- paddle_right  input  10  paddle right x, inclusive
- paddle_top  input  9  paddle top y
- ball_x  output  10  ball centre x
- ball_y  output  9  ball centre y
- moving  output  1  high while in MOVE
- hit  output  1  one-cycle pulse on paddle bounce
- miss  output  1  one-cycle pulse when the ball passes the paddle
- score  output  8  paddle hit count, saturates at 255

## Operation
- States: IDLE, MOVE, MISS.
- Reset value of all outputs and internal state:
  - state IDLE; ball_x=WIDTH/2 (320), ball_y=HEIGHT/2 (240)
  - dx=+STEP, dy=+STEP
  - score=0; hit=0, miss=0, moving=0; tick counter=0
- IDLE: ball parked at its current position.
  - serve=1 → MOVE, tick counter cleared.
- MOVE: tick counter counts 0..TICK_DIV-1 and wraps.
  - At count TICK_DIV-1 (a tick), compute nx=ball_x+dx and ny=ball_y+dy in signed 11-bit arithmetic.
  - serve is ignored in MOVE.
- X axis, evaluated on every tick:
  - nx<RADIUS → ball_x=RADIUS, dx=+STEP.
  - nx>WIDTH-1-RADIUS → ball_x=WIDTH-1-RADIUS, dx=-STEP.
  - Otherwise ball_x=nx.
- Y axis, evaluated on the same tick; priority is top wall > paddle > miss > free move:
  - Top wall: ny<RADIUS → ball_y=RADIUS, dy=+STEP.
  - Paddle: applies when dy>0, ball_y+RADIUS<paddle_top, ny+RADIUS>=paddle_top, and paddle_left<=ball_x<=paddle_right (pre-update ball_x).
    - ball_y=paddle_top-RADIUS, dy=-STEP.
    - hit pulse; score+1, saturating.
  - Miss: ny>HEIGHT-1-RADIUS without a paddle hit → state MISS; ball position is not updated.
  - Free move: otherwise ball_y=ny.
- Both axes are resolved independently on the same tick, so a corner reflects both axes.
- MISS: lasts exactly one cycle.
  - miss=1.
  - Next state IDLE with ball_x=320, ball_y=240 and dy=+STEP.
  - dx and score are unchanged.
- Paddle inputs are sampled only on the tick cycle. They are assumed stable and in range; no validation is performed.

## Timing
- All outputs are registered.
- serve sampled at edge N → moving=1 after edge N.
- First position update lands TICK_DIV cycles after the serve edge, then every TICK_DIV cycles.
- ball_x, ball_y, hit and score change on the edge that ends the tick cycle.
- hit and miss are high for exactly one cycle.
- miss rises on the tick edge; the recentre and moving=0 occur on the following edge.
- rst overrides everything in any state, including mid-tick and during MISS.
- No other handshake: the renderer samples ball_x/ball_y freely. Positions are always within [RADIUS, dimension-1-RADIUS], except that ball_y may sit above paddle_top-RADIUS only as described in Operation.

## Test plan
All scenarios use TICK_DIV=4 for simulation.
- Reset and idle:
  - Stimulus: assert rst, then hold serve=0 for 100 cycles.
  - Required: ball (320,240), moving=0, score=0, and hit=miss=0 throughout.
- Serve and first tick:
  - Stimulus: serve pulse.
  - Required: moving=1 next cycle; ball becomes (322,242) 4 cycles after the serve edge.
  - Follow-up: a second serve during MOVE has no effect on the trajectory.
- Paddle hit:
  - Stimulus: paddle_left=500, paddle_right=560, paddle_top=460; serve.
  - Required at tick 105: ball (530,450), one-cycle hit, score=1, dy negative. Tick 106 gives (532,448).
- Miss:
  - Stimulus: paddle_left=0, paddle_right=90, paddle_top=460; serve.
  - Required: no hit; ball reaches (548,468) at tick 114; miss pulse on tick 115.
  - Next cycle: IDLE, ball (320,240), moving=0, score unchanged.
- Right wall:
  - Stimulus: continue from the hit scenario.
  - Required at tick 155: ball_x clamps to 629 with dx=-2, ball_y=350; tick 156 gives (627,348).
- Reset mid-flight:
  - Stimulus: assert rst two cycles before a tick during MOVE.
  - Required: ball (320,240), IDLE, score=0, and no hit or miss pulse.

Source files
------------

// File: rtl/ball_motion.sv
// ball_motion: Pong ball physics, advancing the ball one step per motion tick.
// Ports:
//   CLOCK_50      system clock
//   rst           synchronous, active-high reset
//   serve         one-cycle launch pulse, honoured only while parked
//   paddle_left   paddle left x, inclusive
//   paddle_right  paddle right x, inclusive
//   paddle_top    paddle top y
//   ball_x/ball_y ball centre, fed straight to the renderer's circle test
//   moving        high from launch until the ball is recentred after a miss
//   hit/miss      one-cycle event pulses
//   score         paddle hit count, saturating at 255
module ball_motion #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int RADIUS   = 10,
    parameter int STEP     = 2,
    parameter int TICK_DIV = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       serve,
    input  logic [9:0] paddle_left,
    input  logic [9:0] paddle_right,
    input  logic [8:0] paddle_top,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       moving,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic signed [10:0] S    = 11'(STEP);
    localparam logic signed [10:0] R    = 11'(RADIUS);
    localparam logic signed [10:0] XMAX = 11'(WIDTH - 1 - RADIUS);
    localparam logic signed [10:0] YMAX = 11'(HEIGHT - 1 - RADIUS);
    localparam logic [9:0] X0 = 10'(WIDTH / 2);
    localparam logic [8:0] Y0 = 9'(HEIGHT / 2);

    typedef enum logic [1:0] {IDLE, MOVE, MISS} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [9:0]      ball_x_n;
    logic [8:0]      ball_y_n;
    logic [7:0]      score_n;
    logic            dx_neg, dx_neg_n, dy_neg, dy_neg_n, hit_n, miss_n;
    logic            tick, on_paddle;
    logic signed [10:0] nx, ny, by, pt;

    // Directions are kept as sign bits; the magnitude is always STEP.
    always_comb begin
        tick      = state == MOVE && cnt == CW'(TICK_DIV - 1);
        nx        = $signed({1'b0, ball_x}) + (dx_neg ? -S : S);
        ny        = $signed({2'b0, ball_y}) + (dy_neg ? -S : S);
        by        = $signed({2'b0, ball_y});
        pt        = $signed({2'b0, paddle_top});
        // Paddle contact only when descending and crossing the paddle line on this step.
        on_paddle = !dy_neg && (by + R < pt) && (ny + R >= pt)
                    && ball_x >= paddle_left && ball_x <= paddle_right;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ball_x_n = ball_x;
        ball_y_n = ball_y;
        dx_neg_n = dx_neg;
        dy_neg_n = dy_neg;
        score_n  = score;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        case (state)
            IDLE: begin
                if (serve) begin
                    state_n = MOVE;
                    cnt_n   = '0;
                end
            end
            MOVE: begin
                cnt_n = tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    if (!(ny > YMAX) || ny < R || on_paddle) begin
                        ball_x_n = nx < R ? R[9:0] : nx > XMAX ? XMAX[9:0] : nx[9:0];
                        dx_neg_n = nx < R ? 1'b0 : nx > XMAX ? 1'b1 : dx_neg;
                    end
                    if (ny < R) begin
                        ball_y_n = R[8:0];
                        dy_neg_n = 1'b0;
                    end else if (on_paddle) begin
                        ball_y_n = paddle_top - 9'(RADIUS);
                        dy_neg_n = 1'b1;
                        hit_n    = 1'b1;
                        score_n  = score + 8'(score != 8'hFF);
                    end else if (ny > YMAX) begin
                        // Position is frozen for the single MISS cycle.
                        state_n = MISS;
                        miss_n  = 1'b1;
                    end else begin
                        ball_y_n = ny[8:0];
                    end
                end
            end
            MISS: begin
                state_n  = IDLE;
                ball_x_n = X0;
                ball_y_n = Y0;
                dy_neg_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ball_x <= X0;
            ball_y <= Y0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
            score  <= '0;
            hit    <= 1'b0;
            miss   <= 1'b0;
            moving <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ball_x <= ball_x_n;
            ball_y <= ball_y_n;
            dx_neg <= dx_neg_n;
            dy_neg <= dy_neg_n;
            score  <= score_n;
            hit    <= hit_n;
            miss   <= miss_n;
            // moving drops together with the recentre that ends MISS.
            moving <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed and randomized checks of ball_motion against an integer physics model.
// Ports: none (top-level bench); drives CLOCK_50, rst, serve and the paddle inputs.
module tb_ball_motion;
    localparam int TD = 4;
    localparam int R  = 10;

    logic       CLOCK_50 = 1'b0;
    logic       rst = 1'b1;
    logic       serve = 1'b0;
    logic [9:0] paddle_left = 10'd500;
    logic [9:0] paddle_right = 10'd560;
    logic [8:0] paddle_top = 9'd460;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       moving, hit, miss;
    logic [7:0] score;

    ball_motion #(.TICK_DIV(TD)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .serve(serve),
        .paddle_left(paddle_left), .paddle_right(paddle_right), .paddle_top(paddle_top),
        .ball_x(ball_x), .ball_y(ball_y), .moving(moving), .hit(hit), .miss(miss), .score(score)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0, checks = 0;
    int mx, my, mdx, mdy, mscore;
    bit flying;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input string tag);
        chk({tag, "_x"}, 32'(ball_x), mx);
        chk({tag, "_y"}, 32'(ball_y), my);
    endtask

    task automatic model_reset();
        mx = 320; my = 240; mdx = 2; mdy = 2; mscore = 0; flying = 0;
    endtask

    // One motion step from the physics rules, in plain integers.
    task automatic model_step(output bit h, output bit m);
        int nx, ny, tx, ty, tdx, tdy, pl, pr, pt;
        pl = int'(paddle_left); pr = int'(paddle_right); pt = int'(paddle_top);
        h = 0; m = 0;
        nx = mx + mdx; ny = my + mdy;
        tx = nx; tdx = mdx; ty = ny; tdy = mdy;
        if (nx < R) begin tx = R; tdx = 2; end
        else if (nx > 639 - R) begin tx = 639 - R; tdx = -2; end
        if (ny < R) begin ty = R; tdy = 2; end
        else if (mdy > 0 && my + R < pt && ny + R >= pt && mx >= pl && mx <= pr) begin
            ty = pt - R; tdy = -2; h = 1;
            if (mscore < 255) mscore++;
        end else if (ny > 479 - R) m = 1;
        if (!m) begin mx = tx; mdx = tdx; my = ty; mdy = tdy; end
    endtask

    task automatic do_reset();
        rst = 1; serve = 0;
        repeat (2) @(posedge CLOCK_50);
        #1 rst = 0;
        model_reset();
        chk_ball("reset");
        chk("reset_moving", 32'(moving), 0);
        chk("reset_score", 32'(score), 0);
    endtask

    task automatic serve_pulse();
        serve = 1;
        @(posedge CLOCK_50);
        #1 serve = 0;
        flying = 1;
        chk("serve_moving", 32'(moving), 1);
        chk_ball("serve");
    endtask

    task automatic run_ticks(input int n, input bit rs);
        bit h, m;
        for (int k = 0; k < n && flying; k++) begin
            for (int c = 0; c < TD; c++) begin
                serve = rs && ($urandom_range(0, 3) == 0);
                @(posedge CLOCK_50);
                #1;
                if (c < TD - 1) begin
                    chk("between_hit", 32'(hit), 0);
                    chk("between_miss", 32'(miss), 0);
                    chk_ball("between");
                end
            end
            serve = 0;
            model_step(h, m);
            chk("tick_hit", 32'(hit), 32'(h));
            chk("tick_miss", 32'(miss), 32'(m));
            chk("tick_moving", 32'(moving), 1);
            chk("tick_score", 32'(score), mscore);
            chk_ball("tick");
            if (m) begin
                @(posedge CLOCK_50);
                #1;
                mx = 320; my = 240; mdy = 2; flying = 0;
                chk("after_miss_miss", 32'(miss), 0);
                chk("after_miss_moving", 32'(moving), 0);
                chk("after_miss_score", 32'(score), mscore);
                chk_ball("after_miss");
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(posedge CLOCK_50);
            #1;
            chk_ball("idle");
            chk("idle_moving", 32'(moving), 0);
            chk("idle_hit", 32'(hit), 0);
            chk("idle_miss", 32'(miss), 0);
            chk("idle_score", 32'(score), 0);
        end

        // Paddle hit, then right wall, with stray serves during flight.
        serve_pulse();
        run_ticks(1, 0);
        chk("first_tick_x", 32'(ball_x), 322);
        chk("first_tick_y", 32'(ball_y), 242);
        run_ticks(104, 1);
        chk("t105_x", 32'(ball_x), 530);
        chk("t105_y", 32'(ball_y), 450);
        chk("t105_hit", 32'(hit), 1);
        chk("t105_score", 32'(score), 1);
        run_ticks(1, 1);
        chk("t106_x", 32'(ball_x), 532);
        chk("t106_y", 32'(ball_y), 448);
        run_ticks(49, 1);
        chk("t155_x", 32'(ball_x), 629);
        chk("t155_y", 32'(ball_y), 350);
        run_ticks(1, 0);
        chk("t156_x", 32'(ball_x), 627);
        chk("t156_y", 32'(ball_y), 348);

        // Reset two cycles before a tick.
        @(posedge CLOCK_50);
        #1 rst = 1;
        @(posedge CLOCK_50);
        #1 rst = 0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            chk_ball("midrst");
            chk("midrst_moving", 32'(moving), 0);
            chk("midrst_score", 32'(score), 0);
            chk("midrst_hit", 32'(hit), 0);
            chk("midrst_miss", 32'(miss), 0);
            @(posedge CLOCK_50);
            #1;
        end

        // Miss with the paddle out of the way.
        paddle_left = 10'd0; paddle_right = 10'd90; paddle_top = 9'd460;
        serve_pulse();
        run_ticks(114, 0);
        chk("t114_x", 32'(ball_x), 548);
        chk("t114_y", 32'(ball_y), 468);
        chk("t114_score", 32'(score), 0);
        run_ticks(1, 0);
        chk("t115_flying", 32'(flying), 0);
        chk("t115_x", 32'(ball_x), 320);
        chk("t115_y", 32'(ball_y), 240);

        // Randomized paddles and flights.
        for (int f = 0; f < 4; f++) begin
            do_reset();
            paddle_left  = 10'($urandom_range(0, 560));
            paddle_right = paddle_left + 10'($urandom_range(20, 79));
            paddle_top   = 9'($urandom_range(300, 470));
            serve_pulse();
            run_ticks(300, 1);
            if (!flying) begin
                serve_pulse();
                run_ticks(150, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
